// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per clock. The quotient goes to LO and the remainder to HI.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// RUN   | iterating one quotient bit per cycle on the operand magnitudes
// FIN   | applying the signs (or the divide-by-zero values) and pulsing done
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic             accept;

    // Operand magnitudes. In signed mode, 0x80000000 becomes 2^31, which still fits as unsigned.
    always_comb begin
        dividend_neg = signed_op & dividend[WIDTH-1];
        divisor_neg  = signed_op & divisor[WIDTH-1];
        dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
        divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
        accept       = (state == IDLE) && start;
    end

    // One restoring step. The partial remainder is WIDTH+1 bits wide.
    // The borrow out of the subtraction is the compare result.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_mag};
        fits   = ~diff[WIDTH];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the counter's terminal value ends the run
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? FIN : RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers: operand capture on accept, then one shift/subtract per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
        end else if (accept) begin
            cnt     <= CW'(WIDTH);
            dvs_mag <= divisor_mag;
            if (divisor == '0) begin
                // The FIN stage passes these values through unchanged.
                rem      <= dividend;
                quo      <= '1;
                neg_q    <= 1'b0;
                neg_r    <= 1'b0;
                zero_div <= 1'b1;
            end else begin
                rem      <= '0;
                quo      <= dividend_mag;
                neg_q    <= dividend_neg ^ divisor_neg;
                neg_r    <= dividend_neg;
                zero_div <= 1'b0;
            end
        end else if (state == RUN) begin
            rem <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
            cnt <= cnt - 1'b1;
        end
    end

    // Visible outputs: results update only in FIN, and busy drops on the edge that raises done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == FIN);
            if (state == FIN) begin
                quotient    <= neg_q ? (~quo + 1'b1) : quo;
                remainder   <= neg_r ? (~rem + 1'b1) : rem;
                div_by_zero <= zero_div;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed and random bench for seq_divider_32.
// Expected results come from plain integer division.
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics using 64-bit integer arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        int     ia;
        int     ib;
        longint la;
        longint lb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            ia = a;
            ib = b;
            la = ia;
            lb = ib;
            q  = 32'(la / lb);
            r  = 32'(la % lb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // One full operation. If inj >= 0, a 9/9 start is pulsed inj cycles after the accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int inj, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          n;
        int          nbusy;
        int          lat;
        model(a, b, s, eq, er, ez);
        lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        n     = 0;
        nbusy = busy ? 1 : 0;
        while (!done && n < 60) begin
            @(negedge clk);
            start = (n == inj);
            if (n == inj) begin
                dividend = 32'd9;
                divisor  = 32'd9;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && busy) nbusy++;
        end
        start = 1'b0;
        chk({tag, " latency"}, n, lat);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " busy_cycles"}, nbusy, (b == 32'd0) ? 0 : 32);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;

        // Reset state
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: unsigned 100/7; done is a single pulse and the results are held afterwards
        run_op(32'd100, 32'd7, 1'b0, -1, "t1");
        chk("t1 q literal", quotient, 32'd14);
        chk("t1 r literal", remainder, 32'd2);
        @(posedge clk);
        #1;
        chk("t1 done pulse", {31'd0, done}, 32'd0);
        chk("t1 q held", quotient, 32'd14);

        // 2: signed sign rules
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, "t2a");
        chk("t2a q literal", quotient, 32'hFFFF_FFFD);
        chk("t2a r literal", remainder, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, "t2b");
        chk("t2b q literal", quotient, 32'hFFFF_FFFD);
        chk("t2b r literal", remainder, 32'd1);

        // 3: divide by zero in both modes, then a normal op clears the flag
        run_op(32'd5, 32'd0, 1'b0, -1, "t3a");
        run_op(32'd5, 32'd0, 1'b1, -1, "t3b");
        chk("t3b q literal", quotient, 32'hFFFF_FFFF);
        chk("t3b r literal", remainder, 32'd5);
        run_op(32'd9, 32'd3, 1'b0, -1, "t3c");
        chk("t3c q literal", quotient, 32'd3);

        // 4: signed overflow case and unsigned maximum
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "t4a");
        chk("t4a q literal", quotient, 32'h8000_0000);
        chk("t4a r literal", remainder, 32'd0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, "t4b");
        chk("t4b q literal", quotient, 32'hFFFF_FFFF);

        // 5: a start pulsed mid-run is ignored; the next start right after done is accepted
        run_op(32'd50, 32'd5, 1'b0, 10, "t5a");
        chk("t5a q literal", quotient, 32'd10);
        chk("t5a r literal", remainder, 32'd0);
        run_op(32'd21, 32'd4, 1'b1, -1, "t5b");

        // 6: reset in the middle of a run
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 busy", {31'd0, busy}, 32'd0);
        chk("t6 done", {31'd0, done}, 32'd0);
        chk("t6 quotient", quotient, 32'd0);
        chk("t6 remainder", remainder, 32'd0);
        chk("t6 dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        chk("t6 no done", seen, 0);
        run_op(32'd8, 32'd3, 1'b0, -1, "t6b");

        // Random operations, with corner values mixed in
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom_range(1, 15);
                4:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
